// File: rtl/init.sv
// Memory-initialisation engine: on a ready/enable handshake, sweeps all 256
// entries of an 8-bit RAM writing entry i with value i, one write per clock.
module init (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       rdy,
    output logic [7:0] addr,
    output logic [7:0] wrdata,
    output logic       wren
);

    localparam int unsigned ADDR_W = 8;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(255);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;

    // rst_n is active-high here: a 1 forces the idle state.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state  <= IDLE;
            rdy    <= 1'b1;
            wren   <= 1'b0;
            addr   <= '0;
            wrdata <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (en) begin
                        state  <= WRITE;
                        rdy    <= 1'b0;
                        wren   <= 1'b1;
                        addr   <= '0;
                        wrdata <= '0;
                    end
                end
                WRITE: begin
                    if (addr == LAST_ADDR) begin
                        // Final write already presented; hold 255 in DONE.
                        state <= DONE;
                        rdy   <= 1'b1;
                        wren  <= 1'b0;
                    end else begin
                        addr   <= ADDR_W'(addr + 1'b1);
                        wrdata <= ADDR_W'(addr + 1'b1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    rdy    <= 1'b1;
                    wren   <= 1'b0;
                    addr   <= '0;
                    wrdata <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_init.sv
// Directed bench for init: drives handshakes, checks every sweep cycle and
// keeps a small RAM model fed from the write port.
module tb_init;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       rdy;
    logic [7:0] addr;
    logic [7:0] wrdata;
    logic       wren;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] mem [256];
    int         wr_cnt = 0;

    init dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .rdy    (rdy),
        .addr   (addr),
        .wrdata (wrdata),
        .wren   (wren)
    );

    always #5 clk = ~clk;

    // RAM model: samples the write port on every rising edge.
    always @(posedge clk) begin
        if (wren === 1'b1) begin
            mem[addr] = wrdata;
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_done(input string tag);
        check({tag, "_rdy"},    32'(rdy),    32'd1);
        check({tag, "_wren"},   32'(wren),   32'd0);
        check({tag, "_addr"},   32'(addr),   32'd255);
        check({tag, "_wrdata"}, 32'(wrdata), 32'd255);
    endtask

    // Handshake: en high across exactly one rising edge (T0), then low.
    task automatic start_pulse();
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1 en = 1'b0;
    endtask

    // Called just after T0; checks cycles T0+0..T0+255 then the DONE cycle.
    task automatic sweep(input string tag, input int poke_at);
        int bad = 0;
        int w0 = wr_cnt;
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            if (addr !== 8'(k) || wrdata !== 8'(k) || wren !== 1'b1 || rdy !== 1'b0)
                bad++;
            if (poke_at >= 0 && k == poke_at)     en = 1'b1;
            if (poke_at >= 0 && k == poke_at + 1) en = 1'b0;
        end
        check({tag, "_seq_errs"}, 32'(bad), 32'd0);
        @(negedge clk);
        check_done({tag, "_done"});
        check({tag, "_writes"}, 32'(wr_cnt - w0), 32'd256);
    endtask

    initial begin
        int bad;
        int w0;
        bit hit;

        rst_n = 1'b1;
        en    = 1'b0;

        // Reset held for 3 cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        check("rst_rdy",    32'(rdy),    32'd1);
        check("rst_wren",   32'(wren),   32'd0);
        check("rst_addr",   32'(addr),   32'd0);
        check("rst_wrdata", 32'(wrdata), 32'd0);
        w0 = wr_cnt;
        repeat (5) @(negedge clk);
        check("idle_no_writes", 32'(wr_cnt - w0), 32'd0);
        check("idle_rdy",       32'(rdy),         32'd1);

        // Single sweep plus RAM readback
        start_pulse();
        sweep("sweep1", -1);
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (mem[i] !== 8'(i)) bad++;
        check("ram_identity_errs", 32'(bad), 32'd0);
        w0 = wr_cnt;
        repeat (5) @(negedge clk);
        check("done_hold_writes", 32'(wr_cnt - w0), 32'd0);
        check("done_hold_addr",   32'(addr),        32'd255);
        check("done_hold_rdy",    32'(rdy),         32'd1);

        // Restart from DONE with a stray en pulse 100 cycles in
        start_pulse();
        sweep("busy_en", 100);

        // Mid-sweep reset when addr reaches 0x40
        start_pulse();
        hit = 1'b0;
        for (int c = 0; c < 300 && !hit; c++) begin
            @(negedge clk);
            if (addr === 8'h40) hit = 1'b1;
        end
        check("midrst_reached_40", 32'(hit), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        check("midrst_rdy",    32'(rdy),    32'd1);
        check("midrst_wren",   32'(wren),   32'd0);
        check("midrst_addr",   32'(addr),   32'd0);
        check("midrst_wrdata", 32'(wrdata), 32'd0);
        start_pulse();
        sweep("post_rst", -1);

        // en held high: back-to-back sweeps with one DONE cycle between
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        sweep("held1", -1);
        sweep("held2", -1);
        en = 1'b0;
        repeat (3) @(negedge clk);
        check_done("held_end");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/init.md
# init

Memory-initialisation engine that fills a 256-entry, 8-bit-wide RAM with the identity pattern: entry i is written with value i, for i = 0..255. It sits between a top-level controller and the write port of a single-port on-chip RAM. It uses a ready/enable handshake, so a controller can start it, wait for completion, and then hand the RAM to the next pipeline stage.

## Interface
- Parameters: none. Address width and data width are fixed at 8 bits; depth is fixed at 256.
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  reset; synchronous and active-high, i.e. asserted when rst_n = 1, sampled on the rising edge of clk.
- en  input  1  start request; acted on only in a cycle where rdy = 1.
- rdy  output  1  high when the block is idle or finished and can accept en.
- addr  output  8  RAM write address.
- wrdata  output  8  RAM write data; always equal to addr.
- wren  output  1  RAM write enable; one write per cycle while high.

## Operation
- All outputs are registered.
- The state register is named `state`. Its encodings are IDLE, WRITE and DONE.
- IDLE:
  - rdy = 1, wren = 0, addr = 0, wrdata = 0.
  - If en = 1 at a rising edge, go to WRITE with addr = 0.
- WRITE:
  - rdy = 0, wren = 1, wrdata = addr.
  - Each cycle, if addr < 255, addr increments by 1 and the block stays in WRITE.
  - If addr = 255, go to DONE. addr never wraps to 0 inside WRITE.
- DONE:
  - rdy = 1, wren = 0, addr holds 255, wrdata holds 255.
  - If en = 1 at a rising edge, restart: go to WRITE with addr = 0 and rewrite all 256 entries.
  - Otherwise stay in DONE indefinitely.
- en is ignored whenever rdy = 0. This includes en held high continuously through WRITE.
- en held high continuously from IDLE produces exactly one 256-write sweep, then enters DONE, then immediately restarts on the next edge. Controllers must deassert en after the handshake if a single sweep is wanted.
- Reset has priority over everything, including reset asserted mid-sweep. It returns state to IDLE with rdy = 1, wren = 0, addr = 0, wrdata = 0. Any partially written RAM contents are left as they are.
- Illegal or unused state encodings recover to IDLE on the next edge.

## Timing
- Reset values: rdy = 1, wren = 0, addr = 0, wrdata = 0, state = IDLE.
- Handshake: a start is accepted at edge T0 when rdy = 1 and en = 1.
- After edge T0: rdy = 0, wren = 1, addr = 0.
- After edge T0 + k, for k = 0..255: addr = k, wrdata = k, wren = 1.
- After edge T0 + 256: state = DONE, rdy = 1, wren = 0, addr = 255.
- Latency: exactly 256 consecutive write cycles with no gaps. rdy is low for exactly 256 cycles.
- The RAM samples addr, wrdata and wren on the rising edge following their update, one write per clock.
- Restart from DONE has the same timing as a start from IDLE.

## Test plan
- Reset: hold rst_n = 1 for 3 cycles, then release -> rdy = 1, wren = 0, addr = 0, state = IDLE. No writes occur while en = 0.
- Single sweep: pulse en for 1 cycle while rdy = 1. Required response:
  - exactly 256 writes with wren = 1, addr = wrdata = 0x00..0xFF in order, one per cycle;
  - then rdy = 1, wren = 0, addr = 255, state = DONE;
  - a RAM model reads back mem[i] == i for all i.
- en ignored while busy: pulse en again 100 cycles into the sweep -> sweep is unaffected, still 256 writes total, finishing at the original cycle.
- Mid-sweep reset: assert rst_n = 1 when addr = 0x40 -> next edge gives IDLE, rdy = 1, wren = 0, addr = 0. A fresh en then produces a full sweep starting at 0.
- Restart from DONE: pulse en in DONE -> a second complete 256-write sweep, 0..255, ending in DONE again.
- en held high forever from IDLE -> back-to-back sweeps, each 256 writes long. Between sweeps there is exactly one DONE cycle with rdy = 1 and wren = 0.
